// File: rtl/tribus_rx.sv
// tribus_rx: captures settled words from a shared tri-state bus into a small valid/ready FIFO
module tribus_rx #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_y,
  input  logic             bus_c,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             xz_err,
  output logic             overflow,
  output logic [7:0]       word_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             c_on, ref_xz, empty, full, pop, push_try, push;
  // An unknown drive enable must read as "no driver", so only a clean 1 counts
  always_comb begin
    c_on = 1'b0;
    if (bus_c) c_on = 1'b1;
  end
  assign ref_xz   = (^ref_q === 1'bx);
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = rd_ready && !empty;
  assign push_try = (state_q == CAPTURE) && !ref_xz;
  assign push     = push_try && (!full || pop);
  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign xz_err   = (state_q == CAPTURE) && ref_xz;
  assign overflow = overflow_q;
  assign word_cnt = word_cnt_q;
  // Capture FSM: a word must hold steady for SETTLE_CYC samples, then one capture per enable
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (c_on) begin
        state_d = SETTLE;
        ref_d   = bus_y;
        cnt_d   = CW'(1);
      end
      SETTLE: if (!c_on) state_d = IDLE;
      else if (bus_y != ref_q) begin
        ref_d = bus_y;
        cnt_d = CW'(1);
      end else if (cnt_q >= CW'(SETTLE_CYC)) state_d = CAPTURE;
      else cnt_d = cnt_q + CW'(1);
      CAPTURE: state_d = HOLD;
      HOLD: if (!c_on) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // FIFO bookkeeping: a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = ref_q;
    wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push_try && full && !pop);
    word_cnt_d = push ? word_cnt_q + 8'd1 : word_cnt_q;
  end
  // State and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_tribus_rx.sv
// tb_tribus_rx: directed and random frames checked against a run-length/queue reference model
module tb_tribus_rx;
  localparam int S = 2;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_y = 'z;
  logic       bus_c = 1'b0;
  logic       rd_ready = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid, xz_err, overflow;
  logic [7:0] word_cnt;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         rnd_rdy = 1'b0;
  logic [7:0] q[$];
  int         run = 0;
  logic [7:0] last = '0;
  bit         captured = 1'b0;
  bit         cap_pend = 1'b0;
  logic [7:0] cap_val = '0;
  bit         exp_xz = 1'b0;
  bit         exp_ovf = 1'b0;
  logic [7:0] exp_cnt = '0;

  tribus_rx #(.WIDTH(8), .SETTLE_CYC(S), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus_y(bus_y), .bus_c(bus_c),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .xz_err(xz_err), .overflow(overflow), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit pop;
    bit do_push;
    @(posedge clk);
    pop = 1'b0;
    do_push = 1'b0;
    if (rst) begin
      q.delete();
      run = 0; captured = 1'b0; cap_pend = 1'b0;
      exp_xz = 1'b0; exp_ovf = 1'b0; exp_cnt = '0;
    end else begin
      pop = rd_ready && (q.size() > 0);
      exp_xz = 1'b0;
      if (cap_pend) begin
        cap_pend = 1'b0;
        if (^cap_val !== 1'bx) begin
          if (q.size() == D && !pop) exp_ovf = 1'b1;
          else do_push = 1'b1;
        end
      end
      if (pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(cap_val);
        exp_cnt++;
      end
      if (bus_c === 1'b1) begin
        if (!captured) begin
          if (run > 0 && bus_y === last) run++;
          else begin
            last = bus_y;
            run = 1;
          end
          if (run == S + 1) begin
            captured = 1'b1;
            cap_pend = 1'b1;
            cap_val = last;
            exp_xz = (^last === 1'bx);
          end
        end
      end else begin
        run = 0;
        captured = 1'b0;
      end
    end
    #1;
    chk("rd_valid", rd_valid, q.size() > 0);
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
    chk("word_cnt", word_cnt, exp_cnt);
    chk("overflow", overflow, exp_ovf);
    chk("xz_err", xz_err, exp_xz);
    if (rnd_rdy) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic frame(input logic [7:0] v1, input int n1, input logic [7:0] v2, input int n2, input int gap);
    bus_c = 1'b1;
    bus_y = v1;
    repeat (n1) step();
    bus_y = v2;
    repeat (n2) step();
    bus_c = 1'b0;
    bus_y = 'z;
    repeat (gap) step();
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_rd_data", rd_data, 8'h00);
    frame(8'h3C, 6, 8'h3C, 0, 3);
    chk("first_word_cnt", word_cnt, 8'd1);
    frame(8'h3C, 1, 8'h33, 5, 3);
    frame('x, 5, 'x, 0, 3);
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) frame(8'(i), 5, 8'(i), 0, 2);
    chk("overflow_set", overflow, 1'b1);
    rd_ready = 1'b1;
    repeat (8) step();
    bus_c = 1'b1;
    bus_y = 8'hA5;
    repeat (2) step();
    rst = 1'b1;
    bus_c = 1'b0;
    bus_y = 'z;
    step();
    rst = 1'b0;
    step();
    chk("midsettle_rst_rd_data", rd_data, 8'h00);
    chk("midsettle_rst_cnt", word_cnt, 8'h00);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        frame(8'($urandom), $urandom_range(1, 3), 8'($urandom), $urandom_range(1, 6), $urandom_range(2, 3));
      else
        frame(8'($urandom), $urandom_range(1, 7), 8'h00, 0, $urandom_range(2, 3));
    end
    rnd_rdy = 1'b0;
    rd_ready = 1'b1;
    repeat (8) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
